// File: rtl/tpm_tis_regs.sv
// TPM TIS register block behind an LPC TPM-cycle peripheral: locality/status/burst/FIFO/DID_VID
// registers plus command and response byte FIFOs bridging the LPC side to a TPM engine.
module tpm_tis_regs #(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] DID_VID = 32'h0001_1050
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wrData,
  input  logic        didWrite,
  input  logic        didRead,
  output logic [7:0]  rdData,
  output logic [7:0]  cmdByte,
  output logic        cmdValid,
  input  logic        cmdReady,
  input  logic [7:0]  rspByte,
  input  logic        rspValid,
  input  logic        rspLast,
  output logic        rspReady,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READY, ST_RECEPTION, ST_EXECUTION, ST_COMPLETION
  } state_t;

  state_t          state_q;
  logic            locality_q;
  logic [AW-1:0]   cmd_wp_q, cmd_rp_q, rsp_wp_q, rsp_rp_q;
  logic [CW-1:0]   cmd_cnt_q, rsp_cnt_q;
  logic [31:0]     size_q;
  logic [7:0]      cmd_mem [DEPTH];
  logic [7:0]      rsp_mem [DEPTH];

  logic wr_access, wr_sts, wr_fifo, flush_access, sts_ready, sts_go;
  logic cmd_full, expect_w, data_avail;
  logic cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic [8:0] burst_cmd, burst_rsp;

  assign dbg_state_o = state_q;

  // Only ACCESS writes get through without an active locality.
  assign wr_access    = didWrite && (addr == 16'h0000);
  assign wr_sts       = didWrite && locality_q && (addr == 16'h0018);
  assign wr_fifo      = didWrite && locality_q && (addr == 16'h0024);
  assign flush_access = wr_access && wrData[5];

  assign cmd_full   = (cmd_cnt_q == FULL);
  assign expect_w   = (state_q == ST_RECEPTION) && !cmd_full &&
                      ((cmd_cnt_q < CW'(6)) || ({{(32-CW){1'b0}}, cmd_cnt_q} < size_q));
  assign data_avail = (state_q == ST_COMPLETION) && (rsp_cnt_q != '0);

  assign sts_ready = wr_sts && wrData[6] &&
                     (state_q inside {ST_IDLE, ST_RECEPTION, ST_COMPLETION});
  assign sts_go    = wr_sts && wrData[5] && (state_q == ST_RECEPTION) && !expect_w;

  // Engine handshakes: a byte moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and each side may hold its signal for any number of cycles.
  assign cmdValid = (state_q == ST_EXECUTION) && (cmd_cnt_q != '0);
  assign cmdByte  = cmd_mem[cmd_rp_q];
  assign rspReady = (state_q == ST_EXECUTION) && (rsp_cnt_q != FULL);

  assign cmd_push = wr_fifo && (state_q inside {ST_READY, ST_RECEPTION}) && !cmd_full;
  assign cmd_pop  = cmdValid && cmdReady;
  assign rsp_push = rspValid && rspReady;
  assign rsp_pop  = didRead && (addr == 16'h0024) && data_avail;

  assign burst_cmd = DEPTH9 - 9'(cmd_cnt_q);
  assign burst_rsp = 9'(rsp_cnt_q);

  always_comb begin
    rdData = 8'hFF;
    case (addr)
      16'h0000: rdData = {1'b1, 1'b0, locality_q, 3'b000, 1'b0, 1'b0};
      16'h0018: rdData = {1'b1, state_q == ST_READY, 1'b0, data_avail, expect_w, 3'b000};
      16'h0019: begin
        if (state_q inside {ST_READY, ST_RECEPTION}) rdData = burst_cmd[7:0];
        else if (state_q == ST_COMPLETION)           rdData = burst_rsp[7:0];
        else                                         rdData = 8'h00;
      end
      16'h001A: rdData = 8'h00;
      16'h0024: if (data_avail) rdData = rsp_mem[rsp_rp_q];
      16'h0F00: rdData = DID_VID[7:0];
      16'h0F01: rdData = DID_VID[15:8];
      16'h0F02: rdData = DID_VID[23:16];
      16'h0F03: rdData = DID_VID[31:24];
      default:  rdData = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= wrData;
    if (rsp_push) rsp_mem[rsp_wp_q] <= rspByte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      locality_q <= 1'b0;
      cmd_wp_q   <= '0;
      cmd_rp_q   <= '0;
      cmd_cnt_q  <= '0;
      rsp_wp_q   <= '0;
      rsp_rp_q   <= '0;
      rsp_cnt_q  <= '0;
      size_q     <= '0;
    end else begin
      if (flush_access)                 locality_q <= 1'b0;
      else if (wr_access && wrData[1])  locality_q <= 1'b1;

      if (flush_access || sts_ready) begin
        state_q   <= flush_access ? ST_IDLE : ST_READY;
        cmd_wp_q  <= '0;
        cmd_rp_q  <= '0;
        cmd_cnt_q <= '0;
        rsp_wp_q  <= '0;
        rsp_rp_q  <= '0;
        rsp_cnt_q <= '0;
        size_q    <= '0;
      end else begin
        if (cmd_push) begin
          cmd_wp_q  <= cmd_wp_q + AW'(1);
          cmd_cnt_q <= cmd_cnt_q + CW'(1);
          state_q   <= ST_RECEPTION;
          // Header bytes 2..5 carry the big-endian command size.
          if (cmd_cnt_q >= CW'(2) && cmd_cnt_q <= CW'(5)) size_q <= {size_q[23:0], wrData};
        end
        if (sts_go) state_q <= ST_EXECUTION;
        if (cmd_pop) begin
          cmd_rp_q  <= cmd_rp_q + AW'(1);
          cmd_cnt_q <= cmd_cnt_q - CW'(1);
        end
        if (rsp_push) begin
          rsp_wp_q  <= rsp_wp_q + AW'(1);
          rsp_cnt_q <= rsp_cnt_q + CW'(1);
        end
        // The final response byte ends execution; unsent command bytes are dropped.
        if (rsp_push && rspLast) begin
          state_q   <= ST_COMPLETION;
          cmd_wp_q  <= '0;
          cmd_rp_q  <= '0;
          cmd_cnt_q <= '0;
        end
        if (rsp_pop) begin
          rsp_rp_q  <= rsp_rp_q + AW'(1);
          rsp_cnt_q <= rsp_cnt_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tpm_tis_regs.sv
// Bench for tpm_tis_regs: directed register scenarios plus a randomized mix of LPC and engine
// traffic, all checked against a queue-based model of the TIS register behaviour.
module tb_tpm_tis_regs;

  localparam int          DEPTH   = 64;
  localparam logic [31:0] DID_VID = 32'h0001_1050;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wrData = 8'h00;
  logic        didWrite = 1'b0, didRead = 1'b0;
  logic [7:0]  rdData, cmdByte;
  logic        cmdValid, cmdReady = 1'b0;
  logic [7:0]  rspByte = 8'h00;
  logic        rspValid = 1'b0, rspLast = 1'b0;
  logic        rspReady;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  tpm_tis_regs #(.DEPTH(DEPTH), .DID_VID(DID_VID)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .didWrite(didWrite),
    .didRead(didRead), .rdData(rdData), .cmdByte(cmdByte), .cmdValid(cmdValid),
    .cmdReady(cmdReady), .rspByte(rspByte), .rspValid(rspValid), .rspLast(rspLast),
    .rspReady(rspReady), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_READY, P_RECEP, P_EXEC, P_COMP} phase_t;
  phase_t     m_phase = P_IDLE;
  logic       m_loc = 1'b0;
  logic [7:0] cmd_exp_q[$];
  logic [7:0] rsp_exp_q[$];
  logic [7:0] dir_cmd [12];

  function automatic void m_reset();
    m_phase = P_IDLE; m_loc = 1'b0;
    cmd_exp_q.delete(); rsp_exp_q.delete();
  endfunction

  function automatic logic m_expect();
    int len;
    logic [31:0] sz;
    len = cmd_exp_q.size();
    if (m_phase != P_RECEP || len == DEPTH) return 1'b0;
    if (len < 6) return 1'b1;
    sz = {cmd_exp_q[2], cmd_exp_q[3], cmd_exp_q[4], cmd_exp_q[5]};
    return 32'(len) < sz;
  endfunction

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    logic [7:0] v;
    v = 8'hFF;
    case (a)
      16'h0000: v = 8'h80 | (m_loc ? 8'h20 : 8'h00);
      16'h0018: v = 8'h80 | ((m_phase == P_READY) ? 8'h40 : 8'h00)
                    | ((m_phase == P_COMP && rsp_exp_q.size() > 0) ? 8'h10 : 8'h00)
                    | (m_expect() ? 8'h08 : 8'h00);
      16'h0019: begin
        if (m_phase == P_READY || m_phase == P_RECEP) v = 8'(DEPTH - cmd_exp_q.size());
        else if (m_phase == P_COMP)                   v = 8'(rsp_exp_q.size());
        else                                          v = 8'h00;
      end
      16'h001A: v = 8'h00;
      16'h0024: if (m_phase == P_COMP && rsp_exp_q.size() > 0) v = rsp_exp_q[0];
      16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03: v = 8'(DID_VID >> (8 * int'(a[1:0])));
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h0000) begin
      if (d[5]) begin m_loc = 1'b0; cmd_exp_q.delete(); rsp_exp_q.delete(); m_phase = P_IDLE; end
      else if (d[1]) m_loc = 1'b1;
    end else if (m_loc) begin
      if (a == 16'h0018) begin
        if (d[6] && (m_phase == P_IDLE || m_phase == P_RECEP || m_phase == P_COMP)) begin
          cmd_exp_q.delete(); rsp_exp_q.delete(); m_phase = P_READY;
        end else if (d[5] && m_phase == P_RECEP && !m_expect()) m_phase = P_EXEC;
      end else if (a == 16'h0024) begin
        if ((m_phase == P_READY || m_phase == P_RECEP) && cmd_exp_q.size() < DEPTH) begin
          cmd_exp_q.push_back(d); m_phase = P_RECEP;
        end
      end
    end
  endfunction

  function automatic void m_read(input logic [15:0] a);
    if (a == 16'h0024 && m_phase == P_COMP && rsp_exp_q.size() > 0) void'(rsp_exp_q.pop_front());
  endfunction

  // ---------------- drivers ----------------
  task automatic lpc_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; wrData = d; didWrite = 1'b1;
    @(posedge clk); #1;
    didWrite = 1'b0;
    m_write(a, d);
  endtask

  task automatic lpc_read(input logic [15:0] a, output logic [7:0] got, output logic [7:0] exp);
    addr = a; exp = m_rd(a);
    #1; got = rdData;
    didRead = 1'b1;
    @(posedge clk); #1;
    didRead = 1'b0;
    m_read(a);
  endtask

  task automatic eng_step(input logic rdy, input logic vld, input logic [7:0] b, input logic last,
                          output logic obs_cv, output logic [7:0] obs_cb, output logic obs_rr,
                          output logic exp_cv, output logic [7:0] exp_cb, output logic exp_rr);
    cmdReady = rdy; rspValid = vld; rspByte = b; rspLast = last;
    exp_cv = (m_phase == P_EXEC) && (cmd_exp_q.size() > 0);
    exp_cb = exp_cv ? cmd_exp_q[0] : 8'h00;
    exp_rr = (m_phase == P_EXEC) && (rsp_exp_q.size() < DEPTH);
    #1; obs_cv = cmdValid; obs_cb = cmdByte; obs_rr = rspReady;
    @(posedge clk); #1;
    cmdReady = 1'b0; rspValid = 1'b0; rspLast = 1'b0;
    if (exp_cv && rdy) void'(cmd_exp_q.pop_front());
    if (exp_rr && vld) begin
      rsp_exp_q.push_back(b);
      if (last) begin m_phase = P_COMP; cmd_exp_q.delete(); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] g, e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmdValid !== 1'b0) begin errors++; $display("FAIL reset_cmdValid got %b exp 0", cmdValid); end
    checks++; if (rspReady !== 1'b0) begin errors++; $display("FAIL reset_rspReady got %b exp 0", rspReady); end
    reset = 1'b0; m_reset();
    lpc_read(16'h0000, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL reset_access got %h exp 80", g); end
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL reset_sts got %h exp 80", g); end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL reset_burst got %h exp 00", g); end
    lpc_read(16'h0024, g, e);
    checks++; if (g !== 8'hFF) begin errors++; $display("FAIL reset_fifo got %h exp ff", g); end
  endtask

  task automatic test_did_vid();
    logic [7:0] g, e;
    logic [7:0] vid [4];
    vid[0] = 8'h50; vid[1] = 8'h10; vid[2] = 8'h01; vid[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      lpc_read(16'h0F00 + 16'(i), g, e);
      checks++; if (g !== vid[i]) begin errors++; $display("FAIL did_vid_%0d got %h exp %h", i, g, vid[i]); end
    end
    lpc_read(16'h0030, g, e);
    checks++; if (g !== 8'hFF) begin errors++; $display("FAIL unmapped got %h exp ff", g); end
    lpc_read(16'h001A, g, e);
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL burst_hi got %h exp 00", g); end
  endtask

  task automatic test_locality();
    logic [7:0] g, e;
    lpc_write(16'h0024, 8'h5A);
    lpc_write(16'h0018, 8'h40);
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL noloc_sts got %h exp 80", g); end
    lpc_write(16'h0000, 8'h02);
    lpc_read(16'h0000, g, e);
    checks++; if (g !== 8'hA0) begin errors++; $display("FAIL loc_access got %h exp a0", g); end
    lpc_write(16'h0018, 8'h40);
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'hC0) begin errors++; $display("FAIL ready_sts got %h exp c0", g); end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'd64) begin errors++; $display("FAIL ready_burst got %0d exp 64", g); end
  endtask

  task automatic test_reception();
    logic [7:0] g, e;
    dir_cmd[0] = 8'h80; dir_cmd[1] = 8'h01; dir_cmd[2] = 8'h00;
    dir_cmd[3] = 8'h00; dir_cmd[4] = 8'h00; dir_cmd[5] = 8'h0C;
    for (int i = 6; i < 12; i++) dir_cmd[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      lpc_write(16'h0024, dir_cmd[i]);
      lpc_read(16'h0018, g, e);
      checks++;
      if (g !== ((i < 11) ? 8'h88 : 8'h80)) begin
        errors++; $display("FAIL recv_sts_%0d got %h exp %h", i + 1, g, (i < 11) ? 8'h88 : 8'h80);
      end
    end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'd52) begin errors++; $display("FAIL recv_burst got %0d exp 52", g); end
  endtask

  task automatic test_execution();
    logic [7:0] g, e, ocb, ecb;
    logic ocv, orr, ecv, err;
    logic [7:0] rb [10];
    int beats = 0;
    lpc_write(16'h0018, 8'h20);
    for (int c = 0; c < 40 && beats < 12; c++) begin
      eng_step(1'b1, 1'b0, 8'h00, 1'b0, ocv, ocb, orr, ecv, ecb, err);
      if (ocv) begin
        checks++; if (ocb !== dir_cmd[beats]) begin errors++; $display("FAIL cmd_beat_%0d got %h exp %h", beats, ocb, dir_cmd[beats]); end
        beats++;
      end
    end
    checks++; if (beats != 12) begin errors++; $display("FAIL cmd_beats got %0d exp 12", beats); end
    for (int i = 0; i < 10; i++) begin
      rb[i] = 8'($urandom);
      eng_step(1'b0, 1'b1, rb[i], i == 9, ocv, ocb, orr, ecv, ecb, err);
      checks++; if (orr !== 1'b1) begin errors++; $display("FAIL rsp_ready_%0d got %b exp 1", i, orr); end
    end
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h90) begin errors++; $display("FAIL comp_sts got %h exp 90", g); end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'd10) begin errors++; $display("FAIL comp_burst got %0d exp 10", g); end
    for (int i = 0; i < 10; i++) begin
      lpc_read(16'h0024, g, e);
      checks++; if (g !== rb[i]) begin errors++; $display("FAIL rsp_byte_%0d got %h exp %h", i, g, rb[i]); end
    end
    lpc_read(16'h0024, g, e);
    checks++; if (g !== 8'hFF) begin errors++; $display("FAIL rsp_empty got %h exp ff", g); end
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL comp_empty_sts got %h exp 80", g); end
  endtask

  task automatic test_overflow();
    logic [7:0] g, e, ocb, ecb, d;
    logic ocv, orr, ecv, err;
    logic [7:0] sent_q[$];
    int beats = 0;
    lpc_write(16'h0018, 8'h40);
    for (int i = 0; i < 65; i++) begin
      case (i)
        0: d = 8'h80; 1: d = 8'h01; 4: d = 8'h01;
        2, 3, 5: d = 8'h00;
        default: d = 8'($urandom);
      endcase
      if (i < 64) sent_q.push_back(d);
      lpc_write(16'h0024, d);
      if (i == 63) begin
        lpc_read(16'h0018, g, e);
        checks++; if (g !== 8'h80) begin errors++; $display("FAIL full_sts got %h exp 80", g); end
      end
    end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL full_burst got %h exp 00", g); end
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL over_sts got %h exp 80", g); end
    lpc_write(16'h0018, 8'h20);
    for (int c = 0; c < 100 && beats < 65; c++) begin
      eng_step(1'b1, 1'b0, 8'h00, 1'b0, ocv, ocb, orr, ecv, ecb, err);
      if (!ocv && beats == 64) break;
      if (ocv) begin
        checks++;
        if (beats >= 64 || ocb !== sent_q[beats]) begin
          errors++; $display("FAIL over_beat_%0d got %h exp %h", beats, ocb, (beats < 64) ? sent_q[beats] : 8'hxx);
        end
        beats++;
      end
    end
    checks++; if (beats != 64) begin errors++; $display("FAIL over_beats got %0d exp 64", beats); end
    eng_step(1'b0, 1'b1, 8'h3C, 1'b1, ocv, ocb, orr, ecv, ecb, err);
    lpc_read(16'h0024, g, e);
    checks++; if (g !== 8'h3C) begin errors++; $display("FAIL over_rsp got %h exp 3c", g); end
  endtask

  task automatic test_discard();
    logic [7:0] g, e, ocb, ecb;
    logic ocv, orr, ecv, err;
    lpc_write(16'h0018, 8'h40);
    for (int i = 0; i < 10; i++) lpc_write(16'h0024, (i == 5) ? 8'd10 : ((i < 5) ? 8'h00 : 8'(i)));
    lpc_write(16'h0018, 8'h20);
    for (int i = 0; i < 3; i++) begin
      eng_step(1'b1, 1'b0, 8'h00, 1'b0, ocv, ocb, orr, ecv, ecb, err);
      checks++; if (ocv !== 1'b1 || ocb !== ecb) begin errors++; $display("FAIL disc_beat_%0d got %b/%h exp 1/%h", i, ocv, ocb, ecb); end
    end
    eng_step(1'b0, 1'b1, 8'h11, 1'b0, ocv, ocb, orr, ecv, ecb, err);
    eng_step(1'b0, 1'b1, 8'h22, 1'b1, ocv, ocb, orr, ecv, ecb, err);
    eng_step(1'b1, 1'b0, 8'h00, 1'b0, ocv, ocb, orr, ecv, ecb, err);
    checks++; if (ocv !== 1'b0) begin errors++; $display("FAIL disc_cmdValid got %b exp 0", ocv); end
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'd2) begin errors++; $display("FAIL disc_burst got %0d exp 2", g); end
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h90) begin errors++; $display("FAIL disc_sts got %h exp 90", g); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e, ocb, ecb;
    logic ocv, orr, ecv, err;
    lpc_write(16'h0018, 8'h40);
    for (int i = 0; i < 8; i++) lpc_write(16'h0024, (i == 5) ? 8'd8 : 8'h00);
    lpc_write(16'h0018, 8'h20);
    eng_step(1'b0, 1'b0, 8'h00, 1'b0, ocv, ocb, orr, ecv, ecb, err);
    checks++; if (ocv !== 1'b1) begin errors++; $display("FAIL exec_cmdValid got %b exp 1", ocv); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmdValid !== 1'b0) begin errors++; $display("FAIL midrst_cmdValid got %b exp 0", cmdValid); end
    checks++; if (rspReady !== 1'b0) begin errors++; $display("FAIL midrst_rspReady got %b exp 0", rspReady); end
    reset = 1'b0; m_reset();
    lpc_read(16'h0018, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL midrst_sts got %h exp 80", g); end
    lpc_read(16'h0000, g, e);
    checks++; if (g !== 8'h80) begin errors++; $display("FAIL midrst_access got %h exp 80", g); end
    lpc_write(16'h0000, 8'h02);
    lpc_write(16'h0018, 8'h40);
    lpc_read(16'h0019, g, e);
    checks++; if (g !== 8'd64) begin errors++; $display("FAIL midrst_burst got %0d exp 64", g); end
  endtask

  task automatic test_random();
    logic [7:0] g, e, ocb, ecb, d;
    logic [15:0] a;
    logic ocv, orr, ecv, err;
    int len;
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          eng_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(0, 15) == 0, ocv, ocb, orr, ecv, ecb, err);
          checks++; if (ocv !== ecv) begin errors++; $display("FAIL rnd_cmdValid got %b exp %b", ocv, ecv); end
          checks++; if (orr !== err) begin errors++; $display("FAIL rnd_rspReady got %b exp %b", orr, err); end
          if (ecv) begin
            checks++; if (ocb !== ecb) begin errors++; $display("FAIL rnd_cmdByte got %h exp %h", ocb, ecb); end
          end
        end
        3, 4, 5: begin
          len = cmd_exp_q.size();
          if (len >= 2 && len <= 4) d = 8'h00;
          else if (len == 5)        d = 8'($urandom_range(6, 40));
          else                      d = 8'($urandom);
          lpc_write(16'h0024, d);
        end
        6: begin
          case ($urandom_range(0, 5))
            0, 1: d = 8'h40;
            2, 3: d = 8'h20;
            4:    d = 8'h60;
            default: d = 8'($urandom);
          endcase
          lpc_write(($urandom_range(0, 7) == 0) ? 16'h0019 : 16'h0018, d);
        end
        7: begin
          case ($urandom_range(0, 7))
            0: d = 8'h20;
            1: d = 8'($urandom);
            default: d = 8'h02;
          endcase
          lpc_write(16'h0000, d);
        end
        default: begin
          case ($urandom_range(0, 9))
            0: a = 16'h0000; 1: a = 16'h0018; 2: a = 16'h0019; 3: a = 16'h001A;
            4, 5, 6: a = 16'h0024;
            7: a = 16'h0F00 + 16'($urandom_range(0, 3));
            8: a = 16'h0030;
            default: a = 16'($urandom);
          endcase
          lpc_read(a, g, e);
          checks++; if (g !== e) begin errors++; $display("FAIL rnd_read_%h got %h exp %h", a, g, e); end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_did_vid();
    test_locality();
    test_reception();
    test_execution();
    test_overflow();
    test_discard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    checks++; errors++;
    $display("FAIL watchdog run did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
